// File: rtl/ps2_key_decoder_if.sv
// Byte/strobe input and decoded key/history outputs between PS2_Controller and the decoder.
interface ps2_key_decoder_if #(
    parameter int unsigned NUM_KEYS   = 4,
    parameter int unsigned HIST_DEPTH = 4
);
    logic [7:0]              received_data;
    logic                    received_data_en;
    logic                    clear;
    logic [NUM_KEYS-1:0]     key_down;
    logic [NUM_KEYS-1:0]     key_press;
    logic [NUM_KEYS-1:0]     key_release;
    logic                    code_valid;
    logic [7:0]              last_code;
    logic                    last_ext;
    logic                    last_break;
    logic [HIST_DEPTH*8-1:0] history;
    logic [3:0]              hist_count;

    modport master (
        output received_data, received_data_en, clear,
        input  key_down, key_press, key_release, code_valid,
               last_code, last_ext, last_break, history, hist_count
    );

    modport slave (
        input  received_data, received_data_en, clear,
        output key_down, key_press, key_release, code_valid,
               last_code, last_ext, last_break, history, hist_count
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code parser (E0/F0/E1 prefixes) with per-key held/press/release
// tracking and a short history of make codes.
module ps2_key_decoder #(
    parameter int unsigned             NUM_KEYS       = 4,
    parameter logic [NUM_KEYS*8-1:0]   KEY_CODES      = {8'h23, 8'h1B, 8'h1C, 8'h1D},
    parameter logic [NUM_KEYS-1:0]     KEY_EXT        = '0,
    parameter int unsigned             HIST_DEPTH     = 4,
    parameter int unsigned             TIMEOUT_CYCLES = 2_500_000
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    ps2_key_decoder_if.slave    bus
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned HW = HIST_DEPTH * 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_SKIP    = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [2:0]            skip_q, skip_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [NUM_KEYS-1:0]   key_down_q, key_down_d;
    logic [NUM_KEYS-1:0]   key_press_q, key_press_d;
    logic [NUM_KEYS-1:0]   key_release_q, key_release_d;
    logic                  code_valid_q, code_valid_d;
    logic [7:0]            last_code_q, last_code_d;
    logic                  last_ext_q, last_ext_d;
    logic                  last_break_q, last_break_d;
    logic [HW-1:0]         history_q, history_d;
    logic [3:0]            hist_count_q, hist_count_d;
    logic                  rep_valid_q, rep_valid_d;
    logic [7:0]            rep_code_q, rep_code_d;
    logic                  rep_ext_q, rep_ext_d;

    logic                  expire_c;
    state_e                cur_state_c;
    logic                  done_c;
    logic                  brk_c;
    logic                  ext_c;

    // Next-state: a timeout in the same cycle as a strobe lets the byte parse from IDLE.
    always_comb begin
        state_d       = state_q;
        skip_d        = skip_q;
        key_down_d    = key_down_q;
        key_press_d   = '0;
        key_release_d = '0;
        code_valid_d  = 1'b0;
        last_code_d   = last_code_q;
        last_ext_d    = last_ext_q;
        last_break_d  = last_break_q;
        history_d     = history_q;
        hist_count_d  = hist_count_q;
        rep_valid_d   = rep_valid_q;
        rep_code_d    = rep_code_q;
        rep_ext_d     = rep_ext_q;
        done_c        = 1'b0;
        brk_c         = 1'b0;
        ext_c         = 1'b0;

        expire_c    = (state_q != ST_IDLE) && (timer_q == TW'(TIMEOUT_CYCLES - 1));
        cur_state_c = expire_c ? ST_IDLE : state_q;
        timer_d     = (cur_state_c == ST_IDLE) ? '0 : TW'(timer_q + 1'b1);

        if (expire_c) begin
            state_d = ST_IDLE;
            skip_d  = 3'd0;
        end

        if (bus.clear) begin
            key_down_d   = '0;
            history_d    = '0;
            hist_count_d = 4'd0;
            state_d      = ST_IDLE;
            skip_d       = 3'd0;
            timer_d      = '0;
            rep_valid_d  = 1'b0;
        end else if (bus.received_data_en) begin
            timer_d = '0;
            unique case (cur_state_c)
                ST_IDLE: begin
                    unique case (bus.received_data)
                        8'hE0: state_d = ST_EXT;
                        8'hF0: state_d = ST_BRK;
                        8'hE1: begin
                            state_d = ST_SKIP;
                            skip_d  = 3'd7;
                        end
                        8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
                        default: done_c = 1'b1;
                    endcase
                end
                ST_EXT: begin
                    if (bus.received_data == 8'hF0) begin
                        state_d = ST_EXT_BRK;
                    end else if (bus.received_data == 8'hE0) begin
                        state_d = ST_EXT;
                    end else begin
                        done_c = 1'b1;
                        ext_c  = 1'b1;
                    end
                end
                ST_BRK: begin
                    done_c = 1'b1;
                    brk_c  = 1'b1;
                end
                ST_EXT_BRK: begin
                    done_c = 1'b1;
                    brk_c  = 1'b1;
                    ext_c  = 1'b1;
                end
                ST_SKIP: begin
                    if (skip_q <= 3'd1) begin
                        state_d = ST_IDLE;
                        skip_d  = 3'd0;
                    end else begin
                        skip_d = 3'(skip_q - 3'd1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (done_c) begin
                state_d      = ST_IDLE;
                code_valid_d = 1'b1;
                last_code_d  = bus.received_data;
                last_ext_d   = ext_c;
                last_break_d = brk_c;

                for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                    if (bus.received_data == KEY_CODES[8*i +: 8] && ext_c == KEY_EXT[i]) begin
                        if (!brk_c && !key_down_q[i]) begin
                            key_down_d[i]  = 1'b1;
                            key_press_d[i] = 1'b1;
                        end else if (brk_c && key_down_q[i]) begin
                            key_down_d[i]    = 1'b0;
                            key_release_d[i] = 1'b1;
                        end
                    end
                end

                // Typematic repeats of the same make are not re-recorded until a break intervenes.
                if (brk_c) begin
                    rep_valid_d = 1'b0;
                end else begin
                    if (!(rep_valid_q && rep_code_q == bus.received_data && rep_ext_q == ext_c)) begin
                        for (int unsigned j = HIST_DEPTH - 1; j >= 1; j--) begin
                            history_d[8*j +: 8] = history_q[8*(j-1) +: 8];
                        end
                        history_d[7:0] = bus.received_data;
                        if (hist_count_q != 4'(HIST_DEPTH)) begin
                            hist_count_d = 4'(hist_count_q + 4'd1);
                        end
                    end
                    rep_valid_d = 1'b1;
                    rep_code_d  = bus.received_data;
                    rep_ext_d   = ext_c;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            skip_q        <= 3'd0;
            timer_q       <= '0;
            key_down_q    <= '0;
            key_press_q   <= '0;
            key_release_q <= '0;
            code_valid_q  <= 1'b0;
            last_code_q   <= 8'd0;
            last_ext_q    <= 1'b0;
            last_break_q  <= 1'b0;
            history_q     <= '0;
            hist_count_q  <= 4'd0;
            rep_valid_q   <= 1'b0;
            rep_code_q    <= 8'd0;
            rep_ext_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            skip_q        <= skip_d;
            timer_q       <= timer_d;
            key_down_q    <= key_down_d;
            key_press_q   <= key_press_d;
            key_release_q <= key_release_d;
            code_valid_q  <= code_valid_d;
            last_code_q   <= last_code_d;
            last_ext_q    <= last_ext_d;
            last_break_q  <= last_break_d;
            history_q     <= history_d;
            hist_count_q  <= hist_count_d;
            rep_valid_q   <= rep_valid_d;
            rep_code_q    <= rep_code_d;
            rep_ext_q     <= rep_ext_d;
        end
    end

    assign bus.key_down    = key_down_q;
    assign bus.key_press   = key_press_q;
    assign bus.key_release = key_release_q;
    assign bus.code_valid  = code_valid_q;
    assign bus.last_code   = last_code_q;
    assign bus.last_ext    = last_ext_q;
    assign bus.last_break  = last_break_q;
    assign bus.history     = history_q;
    assign bus.hist_count  = hist_count_q;
endmodule
